// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Byte-level command framer between the UART byte receiver/transmitter and
//   the mining core.
//   RX: hunts for 0xAA, cmd, len, payload[len]. A cmd 0 frame with a WORK_LEN
//       payload is presented as work/target with a one-cycle work_valid. A cmd 1
//       frame with a single byte queues a loop-test echo. Any other frame is
//       discarded, as is any frame that stalls mid-way, and frame_err pulses.
//   TX: emits nonce reports (0x55 00 04 n0..n3) and loop echoes
//       (0x55 01 01 b) one byte at a time, honouring tx_busy.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   new_rx_data/rx_data  received byte strobe/data
//   tx_busy            transmitter busy, blocks new bytes
//   new_tx_data/tx_data  byte issue strobe/data (data held between issues)
//   work_valid/work/target  parsed work block and target
//   nonce_valid/nonce  found nonce from the core
//   nonce_drop         nonce arrived while a previous report was still pending
//   frame_err          a frame was discarded
module uart_frame_parser #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int WORK_LEN       = 84
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_rx_data,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         new_tx_data,
  output logic [7:0]   tx_data,
  output logic         work_valid,
  output logic [639:0] work,
  output logic [31:0]  target,
  input  logic         nonce_valid,
  input  logic [31:0]  nonce,
  output logic         nonce_drop,
  output logic         frame_err
);

  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BUF_BYTES = WORK_LEN - 1;  // last byte goes straight to target

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {HUNT, CMD, LEN, DATA} rx_state_t;

  rx_state_t              rx_state;
  logic [7:0]             cmd;
  logic [7:0]             len;
  logic [7:0]             cnt;
  logic [TW-1:0]          idle;
  logic [BUF_BYTES*8-1:0] buffer;

  logic       good_work;
  logic       last_byte;
  logic       timeout;
  logic       loop_hit;
  logic [9:0] wr_off;

  assign good_work = (cmd == 8'd0) && (len == 8'(WORK_LEN));
  assign last_byte = (cnt == len - 8'd1);
  assign wr_off    = {cnt[6:0], 3'b000};
  // idle counts cycles without a byte since the last one; it is held at zero
  // while hunting so a long quiet line never reports an error.
  assign timeout   = (rx_state != HUNT) && !new_rx_data &&
                     (idle == TW'(TIMEOUT_CYCLES - 1));
  assign loop_hit  = new_rx_data && (rx_state == DATA) && last_byte &&
                     (cmd == 8'd1) && (len == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= HUNT;
      cmd        <= '0;
      len        <= '0;
      cnt        <= '0;
      idle       <= '0;
      buffer     <= '0;
      work       <= '0;
      target     <= '0;
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == HUNT || new_rx_data) idle <= '0;
      else                                 idle <= idle + 1'b1;

      if (timeout) begin
        rx_state  <= HUNT;
        frame_err <= 1'b1;
      end else if (new_rx_data) begin
        case (rx_state)
          HUNT: if (rx_data == 8'hAA) rx_state <= CMD;
          CMD: begin
            cmd      <= rx_data;
            rx_state <= LEN;
          end
          LEN: begin
            len <= rx_data;
            cnt <= '0;
            if (rx_data == 8'd0) begin
              rx_state  <= HUNT;
              frame_err <= (cmd > 8'd1);
            end else begin
              rx_state <= DATA;
            end
          end
          DATA: begin
            if (good_work && cnt < 8'(BUF_BYTES)) buffer[wr_off +: 8] <= rx_data;
            cnt <= cnt + 8'd1;
            if (last_byte) begin
              rx_state <= HUNT;
              if (good_work) begin
                work       <= buffer[639:0];
                target     <= {rx_data, buffer[BUF_BYTES*8-1 -: 24]};
                work_valid <= 1'b1;
              end else if (!(cmd == 8'd1 && len == 8'd1)) begin
                frame_err <= 1'b1;
              end
            end
          end
          default: rx_state <= HUNT;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- TX
  typedef enum logic {IDLE, SEND} tx_state_t;

  tx_state_t       tx_state;
  logic [6:0][7:0] frm;
  logic [2:0]      tx_idx;
  logic [2:0]      tx_last;
  logic            nonce_pend;
  logic [31:0]     nonce_q;
  logic            loop_pend;
  logic [7:0]      loop_byte;
  logic            start_nonce;
  logic            start_loop;

  assign start_nonce = (tx_state == IDLE) && nonce_pend;
  assign start_loop  = (tx_state == IDLE) && !nonce_pend && loop_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= IDLE;
      frm         <= '0;
      tx_idx      <= '0;
      tx_last     <= '0;
      nonce_pend  <= 1'b0;
      nonce_q     <= '0;
      loop_pend   <= 1'b0;
      loop_byte   <= '0;
      new_tx_data <= 1'b0;
      tx_data     <= '0;
      nonce_drop  <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      nonce_drop  <= nonce_valid && nonce_pend;

      // The frame is snapshotted on start so the pending slot is free to take
      // the next report while this one is still on the wire.
      if (nonce_valid && !nonce_pend) begin
        nonce_q    <= nonce;
        nonce_pend <= 1'b1;
      end else if (start_nonce) begin
        nonce_pend <= 1'b0;
      end

      if (loop_hit) begin
        loop_pend <= 1'b1;
        loop_byte <= rx_data;
      end else if (start_loop) begin
        loop_pend <= 1'b0;
      end

      case (tx_state)
        IDLE: begin
          tx_idx <= '0;
          if (start_nonce) begin
            frm      <= {nonce_q[31:24], nonce_q[23:16], nonce_q[15:8], nonce_q[7:0],
                         8'h04, 8'h00, 8'h55};
            tx_last  <= 3'd6;
            tx_state <= SEND;
          end else if (start_loop) begin
            frm      <= {8'h00, 8'h00, 8'h00, loop_byte, 8'h01, 8'h01, 8'h55};
            tx_last  <= 3'd3;
            tx_state <= SEND;
          end
        end
        SEND: begin
          // new_tx_data high means a byte went out last cycle: skip one cycle
          // so the transmitter has time to raise tx_busy.
          if (!tx_busy && !new_tx_data) begin
            new_tx_data <= 1'b1;
            tx_data     <= frm[tx_idx];
            tx_idx      <= tx_idx + 3'd1;
            if (tx_idx == tx_last) tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//   Directed sequence with randomised payloads, nonces and byte gaps. Expected
//   TX byte streams and work/target values are built from the frame rules.
//   The UART transmitter is modelled as busy for 87 cycles per byte.
module tb_uart_frame_parser;
  localparam int TO       = 300;
  localparam int BYTE_CYC = 87;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_rx_data = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         tx_busy = 1'b0;
  logic         new_tx_data;
  logic [7:0]   tx_data;
  logic         work_valid;
  logic [639:0] work;
  logic [31:0]  target;
  logic         nonce_valid = 1'b0;
  logic [31:0]  nonce = 32'h0;
  logic         nonce_drop;
  logic         frame_err;

  always #5 clk = ~clk;

  uart_frame_parser #(.TIMEOUT_CYCLES(TO), .WORK_LEN(84)) dut (
    .clk(clk), .rst(rst), .new_rx_data(new_rx_data), .rx_data(rx_data),
    .tx_busy(tx_busy), .new_tx_data(new_tx_data), .tx_data(tx_data),
    .work_valid(work_valid), .work(work), .target(target),
    .nonce_valid(nonce_valid), .nonce(nonce), .nonce_drop(nonce_drop),
    .frame_err(frame_err)
  );

  int vectors = 0, miscompares = 0;
  int wv_cnt = 0, fe_cnt = 0, nd_cnt = 0, viol = 0;
  int busy_cnt = 0;
  logic start_next = 1'b0, prev_tx = 1'b0;
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  logic [7:0] pl[0:255];
  logic [639:0] exp_work = '0;
  logic [31:0]  exp_target = '0;

  // Transmitter model and output event counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; start_next = 1'b0; tx_busy = 1'b0; prev_tx = 1'b0;
    end else begin
      if (new_tx_data) begin
        if (tx_busy || prev_tx) viol++;
        txq.push_back(tx_data);
      end
      if (busy_cnt > 0) busy_cnt--;
      if (start_next) busy_cnt = BYTE_CYC;
      start_next = new_tx_data;
      prev_tx    = new_tx_data;
      tx_busy    = (busy_cnt > 0);
      if (work_valid) wv_cnt++;
      if (frame_err)  fe_cnt++;
      if (nonce_drop) nd_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clr();
    wv_cnt = 0; fe_cnt = 0; nd_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    tick(gap);
    @(posedge clk); #1 rx_data = b; new_rx_data = 1'b1;
    @(posedge clk); #1 new_rx_data = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [7:0] l);
    send_byte(8'hAA, 0);
    send_byte(c, int'($urandom_range(2, 0)));
    send_byte(l, int'($urandom_range(2, 0)));
  endtask

  task automatic send_pl(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(pl[i], int'($urandom_range(2, 0)));
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] l, input int n);
    send_hdr(c, l);
    send_pl(0, n);
  endtask

  task automatic rand_pl(input int n, input bit no_aa);
    for (int i = 0; i < n; i++) begin
      pl[i] = 8'($urandom);
      if (no_aa && pl[i] == 8'hAA) pl[i] = 8'h3C;
    end
  endtask

  // Expected work/target from payload bytes: byte k lands at bits [8k+7:8k].
  task automatic model_work();
    for (int k = 0; k < 80; k++) exp_work[8*k +: 8] = pl[k];
    exp_target = {pl[83], pl[82], pl[81], pl[80]};
  endtask

  task automatic exp_nonce(input logic [31:0] n);
    expq.push_back(8'h55); expq.push_back(8'h00); expq.push_back(8'h04);
    expq.push_back(n[7:0]); expq.push_back(n[15:8]);
    expq.push_back(n[23:16]); expq.push_back(n[31:24]);
  endtask

  task automatic exp_loop(input logic [7:0] b);
    expq.push_back(8'h55); expq.push_back(8'h01); expq.push_back(8'h01);
    expq.push_back(b);
  endtask

  task automatic pulse_nonce(input logic [31:0] v);
    @(posedge clk); #1 nonce = v; nonce_valid = 1'b1;
    @(posedge clk); #1 nonce_valid = 1'b0;
  endtask

  task automatic check_tx(input string tag);
    int n;
    int budget;
    logic [7:0] obs;
    n = expq.size();
    budget = n * 120 + 400;
    while (txq.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    tick(300);
    check($sformatf("%s_count", tag), 640'(txq.size()), 640'(n));
    for (int i = 0; i < n; i++) begin
      obs = (i < txq.size()) ? txq[i] : 8'hxx;
      check($sformatf("%s[%0d]", tag, i), 640'(obs), 640'(expq[i]));
    end
    txq.delete();
    expq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_new_tx_data"}, 640'(new_tx_data), 640'(0));
    check({tag, "_tx_data"},     640'(tx_data),     640'(0));
    check({tag, "_work_valid"},  640'(work_valid),  640'(0));
    check({tag, "_work"},        work,              640'(0));
    check({tag, "_target"},      640'(target),      640'(0));
    check({tag, "_nonce_drop"},  640'(nonce_drop),  640'(0));
    check({tag, "_frame_err"},   640'(frame_err),   640'(0));
  endtask

  task automatic check_work(input string tag);
    check({tag, "_work"},   work,               exp_work);
    check({tag, "_target"}, 640'(target),       640'(exp_target));
  endtask

  logic [31:0] a, b;

  initial begin
    // Reset state
    tick(3);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    tick(2);

    // Loop frame from the plan
    clr();
    pl[0] = 8'h5C;
    send_frame(8'h01, 8'h01, 1);
    exp_loop(8'h5C);
    check_tx("loop5c");
    check("loop5c_wv", 640'(wv_cnt), 640'(0));
    check("loop5c_fe", 640'(fe_cnt), 640'(0));

    // Work frame with payload 00..53
    clr();
    for (int k = 0; k < 84; k++) pl[k] = 8'(k);
    send_frame(8'h00, 8'h54, 84);
    @(negedge clk);
    check("work_seq_wv_next", 640'(work_valid), 640'(1));
    model_work();
    check("work_seq_b0",   640'(work[7:0]),     640'(8'h00));
    check("work_seq_b79",  640'(work[639:632]), 640'(8'h4F));
    check("work_seq_tgt",  640'(target),        640'(32'h53525150));
    check_work("work_seq");
    tick(5);
    check("work_seq_wv_cnt", 640'(wv_cnt), 640'(1));

    // Random work frame with embedded 0xAA bytes
    clr();
    rand_pl(84, 0);
    pl[5] = 8'hAA; pl[6] = 8'hAA; pl[7] = 8'h00;
    send_frame(8'h00, 8'h54, 84);
    @(negedge clk);
    check("work_rnd_wv_next", 640'(work_valid), 640'(1));
    model_work();
    check_work("work_rnd");
    tick(5);
    check("work_rnd_wv_cnt", 640'(wv_cnt), 640'(1));
    check("work_rnd_fe",     640'(fe_cnt), 640'(0));

    // Back-to-back nonce_valid: second is dropped
    clr();
    @(posedge clk); #1 nonce = 32'h12345678; nonce_valid = 1'b1;
    @(posedge clk); #1 nonce = $urandom;
    @(posedge clk); #1 nonce_valid = 1'b0;
    exp_nonce(32'h12345678);
    check_tx("nonce1");
    check("nonce1_drop", 640'(nd_cnt), 640'(1));

    // Nonce arriving during transmission becomes the next report
    clr();
    a = $urandom; b = $urandom;
    pulse_nonce(a);
    tick(100);
    pulse_nonce(b);
    exp_nonce(a); exp_nonce(b);
    check_tx("nonce2");
    check("nonce2_drop", 640'(nd_cnt), 640'(0));

    // Nonce and loop both pending; the later loop byte overwrites the earlier
    clr();
    a = $urandom; b = $urandom;
    pulse_nonce(a);
    tick(20);
    pl[0] = 8'($urandom);
    send_frame(8'h01, 8'h01, 1);
    pl[0] = 8'hA5;
    send_frame(8'h01, 8'h01, 1);
    pulse_nonce(b);
    exp_nonce(a); exp_nonce(b); exp_loop(8'hA5);
    check_tx("tie");
    check("tie_drop", 640'(nd_cnt), 640'(0));

    // Work cmd with wrong length
    clr();
    rand_pl(16, 0);
    send_frame(8'h00, 8'h10, 16);
    tick(5);
    check("badlen_fe", 640'(fe_cnt), 640'(1));
    check("badlen_wv", 640'(wv_cnt), 640'(0));
    check_work("badlen_hold");

    // Unknown cmd with payload, then a good loop frame
    clr();
    rand_pl(2, 0);
    send_frame(8'h07, 8'h02, 2);
    tick(5);
    check("unk_fe", 640'(fe_cnt), 640'(1));
    clr();
    pl[0] = 8'($urandom);
    exp_loop(pl[0]);
    send_frame(8'h01, 8'h01, 1);
    check_tx("unk_then_loop");
    check("unk_then_loop_fe", 640'(fe_cnt), 640'(0));

    // Zero-length frames: unknown cmd errors, known cmd is silent
    clr();
    send_frame(8'h07, 8'h00, 0);
    tick(3);
    check("len0_unk_fe", 640'(fe_cnt), 640'(1));
    clr();
    send_frame(8'h01, 8'h00, 0);
    tick(3);
    check("len0_known_fe", 640'(fe_cnt), 640'(0));

    // Loop cmd with two bytes: error, nothing transmitted
    clr();
    rand_pl(2, 0);
    send_frame(8'h01, 8'h02, 2);
    check_tx("loop_len2");
    check("loop_len2_fe", 640'(fe_cnt), 640'(1));

    // Timeout mid work frame, then a full frame is accepted
    clr();
    rand_pl(84, 0);
    send_frame(8'h00, 8'h54, 10);
    tick(TO + 20);
    check("timeout_fe", 640'(fe_cnt), 640'(1));
    check("timeout_wv", 640'(wv_cnt), 640'(0));
    clr();
    rand_pl(84, 0);
    send_frame(8'h00, 8'h54, 84);
    tick(3);
    model_work();
    check("post_to_wv", 640'(wv_cnt), 640'(1));
    check_work("post_to");

    // A gap just under the timeout does not abandon the frame
    clr();
    rand_pl(84, 0);
    send_frame(8'h00, 8'h54, 40);
    tick(TO - 30);
    send_pl(40, 84);
    tick(3);
    model_work();
    check("near_to_wv", 640'(wv_cnt), 640'(1));
    check("near_to_fe", 640'(fe_cnt), 640'(0));
    check_work("near_to");

    // Reset during a work frame and a nonce frame
    clr();
    pulse_nonce($urandom);
    rand_pl(84, 1);
    send_frame(8'h00, 8'h54, 40);
    tick(150);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    txq.delete(); expq.delete();
    clr();
    send_pl(40, 84);
    check_tx("midrst_tx");
    check("midrst_wv", 640'(wv_cnt), 640'(0));
    check("midrst_fe", 640'(fe_cnt), 640'(0));
    clr();
    rand_pl(84, 0);
    send_frame(8'h00, 8'h54, 84);
    tick(3);
    model_work();
    check("after_rst_wv", 640'(wv_cnt), 640'(1));
    check_work("after_rst");

    check("tx_guard_viol", 640'(viol), 640'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Byte-level command framer between the UART byte receiver/transmitter and the mining core inside uart2core.
- RX side: parses host frames of the form 0xAA, cmd, len, payload[len]. A work frame becomes a 640-bit work block plus a 32-bit target, presented to the core with a one-cycle valid.
- TX side: serialises found-nonce reports and loop-test acknowledges into frames of the form 0x55, cmd, len, payload, one byte at a time, to the UART transmitter.

Parameters:
- TIMEOUT_CYCLES, 1000000: idle cycles between RX bytes inside a frame before the parser abandons it and returns to header hunt.
- WORK_LEN, 84: required payload length of a work frame (80 work bytes + 4 target bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- new_rx_data  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  UART transmitter busy; no new byte may be issued while high
- new_tx_data  out  1  one-cycle strobe, tx_data valid
- tx_data  out  8  byte to transmit
- work_valid  out  1  one-cycle pulse, work/target valid
- work  out  640  work block; payload byte k maps to bits [8k+7:8k], k=0..79
- target  out  32  payload bytes 80..83, byte 80 = bits[7:0]
- nonce_valid  in  1  one-cycle strobe from core, nonce found
- nonce  in  32  found nonce
- nonce_drop  out  1  one-cycle pulse: nonce_valid arrived while a nonce report was still pending
- frame_err  out  1  one-cycle pulse on a discarded frame (bad len, unknown cmd, timeout)

Behaviour:
- Reset values: every output 0; work and target cleared; RX FSM = HUNT; TX FSM = IDLE; pending flags cleared.

RX FSM (advances only on new_rx_data, except for the timeout):
- HUNT: byte 0xAA -> CMD; any other byte is ignored.
- CMD: latch cmd -> LEN.
- LEN: latch len; byte counter cleared.
  - len==0 -> HUNT; if cmd is unknown, also pulse frame_err.
  - otherwise -> DATA.
- DATA: byte k is stored into the shift buffer at offset k.
  - Only cmd 0 with len==WORK_LEN writes the buffer; cmd 1 latches the byte for echo; all other frames are consumed and discarded.
  - On the last byte (counter == len-1) -> HUNT and one of:
    - cmd 0, len==WORK_LEN: work_valid=1 on the cycle after the last byte, with work/target updated on that same cycle. work/target hold until the next good work frame.
    - cmd 1, len==1: set loop_pend, latch the byte as loop_byte.
    - anything else: frame_err pulse.
- Timeout: an inter-byte gap of ≥TIMEOUT_CYCLES in CMD, LEN or DATA -> HUNT and frame_err. The counter restarts on every new_rx_data.
- A 0xAA inside the payload is data, not a resync.

TX side:
- nonce_valid with no nonce pending: latch nonce, set nonce_pend.
- nonce_valid with nonce already pending: keep the old nonce, pulse nonce_drop.
- A new loop byte while loop_pend is set overwrites loop_byte.
- TX FSM IDLE: if nonce_pend, send a nonce frame; else if loop_pend, send a loop frame. Nonce has priority on a tie.
  - Nonce frame = 0x55, 0x00, 0x04, nonce[7:0], [15:8], [23:16], [31:24].
  - Loop frame = 0x55, 0x01, 0x01, loop_byte.
- The pending flag clears when the frame starts. A nonce_valid arriving during transmission becomes the next pending report.
- Byte issue rule:
  - new_tx_data pulses for one cycle only when tx_busy==0 and no byte was issued in the previous cycle. This gives a 1-cycle guard for busy to rise.
  - tx_data is held stable until the next issue.
  - Frames are never interleaved.
- RX and TX run concurrently and independently.
- Reset mid-frame on either side aborts the frame silently; no partial output and no error pulse.

Test Plan:
- Loop frame AA 01 01 5C -> TX bytes 55 01 01 5C in order, one new_tx_data per byte with tx_busy modelled at 87 cycles/byte; no work_valid.
- Work frame AA 00 54 with payload bytes 00..53 -> single work_valid one cycle after the last byte; work[7:0]=00, work[639:632]=4F, target=0x53525150.
- Found nonce: nonce_valid with nonce=0x12345678 -> TX 55 00 04 78 56 34 12. A second nonce_valid during pending -> nonce_drop pulse, one frame only.
- Simultaneous nonce_pend and loop_pend (byte 0xA5) -> nonce frame fully, then 55 01 01 A5.
- Error frames:
  - AA 00 10 + 16 bytes -> frame_err, no work_valid.
  - AA 07 02 xx xx -> frame_err; then a valid loop frame is parsed correctly.
- Feed AA 00 54 + 10 bytes, idle TIMEOUT_CYCLES -> frame_err, HUNT. A subsequent full work frame -> work_valid with correct data.
- Assert rst mid-work-frame -> outputs 0. The remaining bytes (no 0xAA) are ignored; the next full frame is accepted.
